// File: rtl/prg_dma_loader.sv
// PRG loader: strips the 2-byte load-address header and writes the payload into a DMA window; PRG_CHECKSUM_EN adds a payload checksum.
// Latency 1 clk ioctl_wr -> dma_we; no backpressure, out-of-window bytes are dropped and flagged.
module prg_dma_loader #(
  parameter int          MEM_AW     = 14,
  parameter logic [15:0] MEM_BASE   = 16'h0000,
  parameter logic [7:0]  LOAD_INDEX = 8'h41
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [MEM_AW-1:0] dma_addr,
  output logic [7:0]        dma_din,
  output logic              dma_we,
  output logic [15:0]       load_addr,
  output logic [15:0]       end_addr,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_short
`ifdef PRG_CHECKSUM_EN
  ,
  output logic [7:0]        checksum
`endif
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_t;

  state_t      state, state_nxt;
  logic        dl_q;
  logic        first_wr;
  logic        start, stop;
  logic [15:0] tgt, tgt_inc, off;
  logic        in_win;
  logic        unused_addr_hi;

  assign start   = (state == IDLE) && ioctl_download && !dl_q && (ioctl_index == LOAD_INDEX);
  assign stop    = (state != IDLE) && !ioctl_download;
  // Target address wraps at 16 bits, so the upper file-offset bits never matter.
  assign tgt     = load_addr + ioctl_addr[15:0] - 16'd2;
  assign tgt_inc = tgt + 16'd1;
  assign off     = tgt - MEM_BASE;
  assign in_win  = {1'b0, off} < (17'd1 << MEM_AW);
  assign busy    = (state != IDLE);
  assign unused_addr_hi = &{1'b0, ioctl_addr[24:16]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = HDR;
      HDR: begin
        if (stop)                                   state_nxt = IDLE;
        else if (ioctl_wr && ioctl_addr == 25'd1)   state_nxt = DATA;
      end
      DATA: if (stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dl_q      <= 1'b0;
      first_wr  <= 1'b0;
      dma_addr  <= '0;
      dma_din   <= '0;
      dma_we    <= 1'b0;
      load_addr <= '0;
      end_addr  <= '0;
      done      <= 1'b0;
      err_range <= 1'b0;
      err_short <= 1'b0;
`ifdef PRG_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      dl_q   <= ioctl_download;
      dma_we <= 1'b0;
      done   <= stop;
      if (start) begin
        load_addr <= '0;
        end_addr  <= '0;
        err_range <= 1'b0;
        err_short <= 1'b0;
        first_wr  <= 1'b1;
`ifdef PRG_CHECKSUM_EN
        checksum  <= '0;
`endif
      end
      if (state == HDR && ioctl_wr) begin
        if (ioctl_addr == 25'd0) load_addr[7:0]  <= ioctl_dout;
        if (ioctl_addr == 25'd1) load_addr[15:8] <= ioctl_dout;
      end
      if (stop && state == HDR) err_short <= 1'b1;
      // A byte strobed in DATA is handled even if the download drops in the same cycle.
      if (state == DATA && ioctl_wr) begin
`ifdef PRG_CHECKSUM_EN
        checksum <= checksum + ioctl_dout;
`endif
        if (in_win) begin
          dma_we   <= 1'b1;
          dma_addr <= off[MEM_AW-1:0];
          dma_din  <= ioctl_dout;
          first_wr <= 1'b0;
          if (first_wr || tgt_inc > end_addr) end_addr <= tgt_inc;
        end else begin
          err_range <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prg_dma_loader.sv
// Randomised and directed bench for prg_dma_loader against a per-stream reference model.
module tb_prg_dma_loader;

  localparam int          MEM_AW     = 14;
  localparam logic [15:0] MEM_BASE   = 16'h0000;
  localparam logic [7:0]  LOAD_INDEX = 8'h41;
  localparam int          WIN        = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              ioctl_download = 1'b0;
  logic [7:0]        ioctl_index = 8'h00;
  logic              ioctl_wr = 1'b0;
  logic [24:0]       ioctl_addr = '0;
  logic [7:0]        ioctl_dout = '0;
  logic [MEM_AW-1:0] dma_addr;
  logic [7:0]        dma_din;
  logic              dma_we;
  logic [15:0]       load_addr, end_addr;
  logic              busy, done, err_range, err_short;
`ifdef PRG_CHECKSUM_EN
  logic [7:0]        checksum;
`endif

  prg_dma_loader #(.MEM_AW(MEM_AW), .MEM_BASE(MEM_BASE), .LOAD_INDEX(LOAD_INDEX)) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
    .load_addr(load_addr), .end_addr(end_addr), .busy(busy), .done(done),
    .err_range(err_range), .err_short(err_short)
`ifdef PRG_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_we = 0, n_done = 0, n_busy = 0;

  // Expected status, persisting across streams exactly as the outputs should.
  logic [15:0] exp_load = 0, exp_end = 0;
  logic        exp_er = 0, exp_es = 0;
  logic [7:0]  exp_ck = 0;

  always @(negedge clk) begin
    if (dma_we) n_we++;
    if (done)   n_done++;
    if (busy)   n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    @(posedge clk); #1;
  endtask

  // Pulses one byte and returns at the negedge following the clock that registered it.
  task automatic send_byte(input int a, input logic [7:0] d);
    @(posedge clk); #1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    check({tag, "_load"},  load_addr, exp_load);
    check({tag, "_end"},   end_addr,  exp_end);
    check({tag, "_erng"},  err_range, exp_er);
    check({tag, "_eshrt"}, err_short, exp_es);
`ifdef PRG_CHECKSUM_EN
    check({tag, "_cksum"}, checksum,  exp_ck);
`endif
  endtask

  task automatic run_stream(input string tag, input logic [7:0] idx, input logic [7:0] b [$], input int gap_max);
    logic        acc, first, er, win, exp_we;
    logic [15:0] la, endv, tgt, off;
    logic [7:0]  ck;
    int          we0, done0, busy0, nwin;
    acc = (idx == LOAD_INDEX);
    la = 0; endv = 0; er = 0; first = 1; ck = 0; nwin = 0;
    we0 = n_we; done0 = n_done; busy0 = n_busy;
    start_dl(idx);
    if (acc && ($urandom % 2 == 1)) ioctl_index = 8'h00;
    for (int i = 0; i < b.size(); i++) begin
      exp_we = 1'b0;
      if (i == 0)      la[7:0]  = b[i];
      else if (i == 1) la[15:8] = b[i];
      else begin
        tgt = la + 16'(i - 2);
        off = tgt - MEM_BASE;
        win = (int'(off) < WIN);
        ck  = ck + b[i];
        if (win) begin
          exp_we = acc;
          nwin++;
          if (first || (tgt + 16'd1) > endv) endv = tgt + 16'd1;
          first = 0;
        end else er = 1;
      end
      send_byte(i, b[i]);
      check({tag, "_we"}, dma_we, exp_we);
      if (exp_we) begin
        check({tag, "_addr"}, dma_addr, off[MEM_AW-1:0]);
        check({tag, "_din"},  dma_din,  b[i]);
      end
      repeat ($urandom_range(gap_max, 0)) @(posedge clk);
    end
    @(posedge clk); #1;
    ioctl_download = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done"}, done, acc);
    if (acc) begin
      exp_load = la; exp_end = endv; exp_er = er; exp_es = (b.size() < 2); exp_ck = ck;
    end
    repeat (3) @(negedge clk);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_ndone"}, n_done - done0, acc ? 1 : 0);
    check({tag, "_nwe"},   n_we - we0, acc ? nwin : 0);
    if (!acc) check({tag, "_nbusy"}, n_busy - busy0, 0);
    check_status(tag);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [15:0] hdr;
    int len, we0, done0;

    #1;
    check("rst_we", dma_we, 0);
    check("rst_busy", busy, 0);
    check_status("rst");
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    q = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_stream("basic", LOAD_INDEX, q, 2);
    check("basic_load_c", load_addr, 16'h0401);
    check("basic_end_c",  end_addr,  16'h0404);

    q = '{8'hFE, 8'h3F, 8'h11, 8'h22, 8'h33, 8'h44};
    run_stream("edge", LOAD_INDEX, q, 1);
    check("edge_end_c", end_addr, 16'h4000);
    check("edge_er_c",  err_range, 1'b1);

    q = '{8'hFF, 8'hFF, 8'h5A, 8'hA5};
    run_stream("wrap", LOAD_INDEX, q, 1);
    check("wrap_end_c", end_addr, 16'h0001);

    q = '{8'h37};
    run_stream("short", LOAD_INDEX, q, 0);
    check("short_es_c", err_short, 1'b1);

    q = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_stream("noidx", 8'h01, q, 1);

    // Reset in the middle of a payload.
    we0 = n_we; done0 = n_done;
    start_dl(LOAD_INDEX);
    send_byte(0, 8'h00);
    send_byte(1, 8'h10);
    send_byte(2, 8'h99);
    send_byte(3, 8'h98);
    #1 reset_n = 1'b0;
    #1;
    check("arst_we", dma_we, 0);
    check("arst_addr", dma_addr, 0);
    check("arst_din", dma_din, 0);
    check("arst_busy", busy, 0);
    exp_load = 0; exp_end = 0; exp_er = 0; exp_es = 0; exp_ck = 0;
    check_status("arst");
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_ndone", n_done - done0, 0);
    check("arst_nwe", n_we - we0, 2);

    q = '{8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
    run_stream("clean", LOAD_INDEX, q, 0);

`ifdef PRG_CHECKSUM_EN
    q = '{8'h00, 8'h10, 8'h80, 8'h90, 8'h01};
    run_stream("cksum", LOAD_INDEX, q, 1);
    check("cksum_c", checksum, 8'h11);
`endif

    for (int n = 0; n < 30; n++) begin
      case ($urandom % 4)
        0: hdr = 16'($urandom);
        1: hdr = 16'h3FF0 + 16'($urandom % 16);
        2: hdr = 16'hFFF8 + 16'($urandom % 8);
        default: hdr = 16'($urandom % 16'h4000);
      endcase
      len = $urandom % 10;
      q = {};
      for (int i = 0; i < len; i++) begin
        if (i == 0)      q.push_back(hdr[7:0]);
        else if (i == 1) q.push_back(hdr[15:8]);
        else             q.push_back(8'($urandom));
      end
      run_stream("rand", ($urandom % 6 == 0) ? 8'h40 : LOAD_INDEX, q, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
